// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel pipeline: widths, latency,
// strobe bundle and the grey-ramp palette used at reset.
package vga_pkg;
  localparam int RGB_W   = 12;
  localparam int IDX_W   = 4;
  localparam int PAL_N   = 16;
  localparam int LATENCY = 4;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Entry i resets to {i,i,i}
  localparam rgb_t [PAL_N-1:0] PAL_DEFAULT = {
    12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 12'h999, 12'h888,
    12'h777, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111, 12'h000
  };
endpackage

// File: rtl/vga_palette.sv
// 16x12 palette register file: synchronous write, combinational read,
// synchronous reset to the grey ramp.
module vga_palette
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  idx_t waddr,
  input  rgb_t wdata,
  input  idx_t raddr,
  output rgb_t rdata
);
  rgb_t [PAL_N-1:0] pal;

  for (genvar i = 0; i < PAL_N; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst)                              pal[i] <= PAL_DEFAULT[i];
      else if (we && waddr == IDX_W'(i))    pal[i] <= wdata;
    end
  end

  // Same-edge read sees the pre-write value
  assign rdata = pal[raddr];
endmodule

// File: rtl/vga_fb_pixel_pipe.sv
// Framebuffer fetch + palette pixel pipe, fixed 4-clk latency on rgb/strobes.
// Optional colour-bar pattern enabled by VGA_TESTPATTERN_EN.
module vga_fb_pixel_pipe
  import vga_pkg::*;
#(
  parameter int HEIGHT     = 480,
  parameter int WIDTH      = 640,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int AW         = clog2(FB_W * FB_H),
  localparam int RW        = clog2(HEIGHT),
  localparam int CW        = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [RW-1:0] row_in,
  input  logic [CW-1:0] col_in,
  output logic [AW-1:0] fb_addr,
  input  logic [3:0]    fb_data,
  input  logic          pal_we,
  input  logic [3:0]    pal_addr,
  input  logic [11:0]   pal_wdata,
  input  logic          test_mode,
  output logic [11:0]   rgb,
  output logic          hs_out,
  output logic          vs_out,
  output logic          de_out
);
  // sync_q[i] holds the strobes of stage i+1
  sync_t [LATENCY-1:0] sync_q;
  sync_t               sync_in;
  logic [RW-1:0]       row1;
  logic [CW-1:0]       col1;
  logic [RW-1:0]       row_s;
  logic [CW-1:0]       col_s;
  logic                oob_s, oob2, oob3;
  logic [AW-1:0]       addr_s;
  idx_t                pal_raddr;
  rgb_t                pal_rdata;

  assign sync_in = '{de: de_in, hs: hs_in, vs: vs_in};

  // S1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      row1   <= '0;
      col1   <= '0;
    end else begin
      sync_q <= {sync_q[LATENCY-2:0], sync_in};
      row1   <= row_in;
      col1   <= col_in;
    end
  end

  assign row_s  = row1 >> SCALE_LOG2;
  assign col_s  = col1 >> SCALE_LOG2;
  assign oob_s  = (32'(row_s) >= 32'(FB_H)) || (32'(col_s) >= 32'(FB_W));
  assign addr_s = AW'(32'(row_s) * 32'(FB_W) + 32'(col_s));

  // S2: address holds across blanking so the RAM sees no spurious reads
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr <= '0;
      oob2    <= 1'b0;
    end else begin
      oob2 <= sync_q[0].de & oob_s;
      if (sync_q[0].de) fb_addr <= oob_s ? '0 : addr_s;
    end
  end

  // S3: RAM registers fb_data; carry oob alongside
  always_ff @(posedge clk) begin
    if (rst) oob3 <= 1'b0;
    else     oob3 <= oob2;
  end

`ifdef VGA_TESTPATTERN_EN
  logic tm1, tm2, tm3;
  idx_t pat2, pat3;

  always_ff @(posedge clk) begin
    if (rst) begin
      tm1  <= 1'b0;
      tm2  <= 1'b0;
      tm3  <= 1'b0;
      pat2 <= '0;
      pat3 <= '0;
    end else begin
      tm1  <= test_mode;
      tm2  <= tm1;
      tm3  <= tm2;
      pat2 <= IDX_W'(32'(col1) >> 6);
      pat3 <= pat2;
    end
  end

  assign pal_raddr = oob3 ? '0 : (tm3 ? pat3 : fb_data);
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pal_raddr = oob3 ? '0 : fb_data;
`endif

  vga_palette u_pal (
    .clk   (clk),
    .rst   (rst),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .raddr (pal_raddr),
    .rdata (pal_rdata)
  );

  // S4
  always_ff @(posedge clk) begin
    if (rst) rgb <= '0;
    else     rgb <= sync_q[2].de ? pal_rdata : '0;
  end

  assign de_out = sync_q[3].de;
  assign hs_out = sync_q[3].hs;
  assign vs_out = sync_q[3].vs;
endmodule

// File: tb/tb_vga_fb_pixel_pipe.sv
// Scoreboard bench for vga_fb_pixel_pipe (FB_H=100 build so row oob is reachable).
module tb_vga_fb_pixel_pipe;
  localparam int FB_W = 160;
  localparam int FB_H = 100;
  localparam int AW   = 14;
  localparam int NC   = 4096;
`ifdef VGA_TESTPATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1, de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [8:0]    row_in = '0;
  logic [9:0]    col_in = '0;
  logic [AW-1:0] fb_addr;
  logic [3:0]    fb_data = '0;
  logic          pal_we = 1'b0, test_mode = 1'b0;
  logic [3:0]    pal_addr = '0;
  logic [11:0]   pal_wdata = '0;
  logic [11:0]   rgb;
  logic          hs_out, vs_out, de_out;

  always #5 clk = ~clk;

  vga_fb_pixel_pipe #(.FB_H(FB_H)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .row_in(row_in), .col_in(col_in), .fb_addr(fb_addr), .fb_data(fb_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .test_mode(test_mode), .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out),
    .de_out(de_out)
  );

  // External synchronous RAM: data one clk after address
  logic [3:0] mem [2**AW];
  always @(posedge clk) fb_data <= mem[fb_addr];

  typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; logic de; } rexp_t;
  typedef struct { int due; int addr; } aexp_t;
  rexp_t qr[$];
  aexp_t qa[$];

  bit h_rst[NC], h_de[NC], h_hs[NC], h_vs[NC], h_tm[NC];
  int h_row[NC], h_col[NC], h_addr[NC];
  logic [11:0] mpal[16];
  int last_addr = 0;
  int ncyc = 0;
  int checks = 0, errors = 0;

  function automatic void pal_ramp();
    for (int i = 0; i < 16; i++) mpal[i] = {4'(i), 4'(i), 4'(i)};
  endfunction

  // One pixel clock of stimulus; finalises expectations once their inputs are all known
  task automatic step(input bit r, input bit d, input bit h, input bit v,
                      input int row, input int col, input bit tm,
                      input bit we, input int wa, input int wd);
    int c, k, a, idx;
    bit z, oob;
    logic [11:0] e;
    @(posedge clk); #1;
    rst = r; de_in = d; hs_in = h; vs_in = v;
    row_in = 9'(d ? row : 0); col_in = 10'(d ? col : 0);
    test_mode = tm; pal_we = we; pal_addr = 4'(wa); pal_wdata = 12'(wd);
    c = ncyc;
    h_rst[c] = r; h_de[c] = d; h_hs[c] = h; h_vs[c] = v; h_tm[c] = tm;
    h_row[c] = d ? row : 0; h_col[c] = d ? col : 0;
    k = c - 1;
    if (k >= 0) begin
      if (h_rst[k] || h_rst[c]) begin
        a = 0; last_addr = 0;
      end else if (h_de[k]) begin
        oob = (h_row[k] / 4 >= FB_H) || (h_col[k] / 4 >= FB_W);
        a = oob ? 0 : (h_row[k] / 4) * FB_W + h_col[k] / 4;
        last_addr = a;
      end else a = last_addr;
      h_addr[k] = a;
      qa.push_back('{k + 2, a});
    end
    k = c - 3;
    if (k >= 0) begin
      z = h_rst[k] || h_rst[k+1] || h_rst[k+2] || h_rst[k+3];
      if (z) qr.push_back('{k + 4, 12'h000, 1'b0, 1'b0, 1'b0});
      else begin
        oob = (h_row[k] / 4 >= FB_H) || (h_col[k] / 4 >= FB_W);
        idx = (PAT && h_tm[k]) ? (h_col[k] / 64) % 16 : int'(mem[h_addr[k]]);
        e = h_de[k] ? mpal[oob ? 0 : idx] : 12'h000;
        qr.push_back('{k + 4, e, h_hs[k], h_vs[k], h_de[k]});
      end
    end
    if (r) pal_ramp();
    else if (we) mpal[wa] = 12'(wd);
    ncyc = c + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int row, input int col, input bit tm);
    step(0, 1, 0, 0, row, col, tm, 0, 0, 0);
  endtask

  // Monitor: every pixel clock the DUT presents all outputs
  initial begin
    aexp_t ae;
    rexp_t re;
    int cur;
    forever begin
      @(negedge clk);
      cur = ncyc - 1;
      while (qa.size() > 0 && qa[0].due <= cur) begin
        ae = qa.pop_front();
        checks++;
        if (fb_addr !== AW'(ae.addr)) begin
          errors++;
          $display("FAIL fb_addr cyc=%0d got=%0d exp=%0d", cur, fb_addr, ae.addr);
        end
      end
      while (qr.size() > 0 && qr[0].due <= cur) begin
        re = qr.pop_front();
        checks++;
        if (rgb !== re.rgb || hs_out !== re.hs || vs_out !== re.vs || de_out !== re.de) begin
          errors++;
          $display("FAIL pixel cyc=%0d got rgb=%h hs=%b vs=%b de=%b exp rgb=%h hs=%b vs=%b de=%b",
                   cur, rgb, hs_out, vs_out, de_out, re.rgb, re.hs, re.vs, re.de);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[489] = 4'hA;
    mem[1]   = 4'h3;
    mem[2]   = 4'h3;
    mem[3]   = 4'h5;
    pal_ramp();

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Address mapping: row 13 col 37 -> 489, data A -> AAA
    pix(13, 37, 0);
    for (int i = 0; i < 20; i++) pix($urandom_range(0, 479), $urandom_range(0, 639), 0);
    step(0, 1, 0, 0, 5, 5, 0, 1, 5, 12'h0F0);
    // Mid-line reset, then palette entry 5 back to ramp
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 40, $urandom_range(0, 639), 0, 0, 0, 0);
    idle(3);
    pix(0, 12, 0);
    pix(0, 13, 0);
    // Blanking with a 96-clk hs pulse
    for (int i = 0; i < 96; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Palette write colliding with an index-3 lookup
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    pix(0, 4, 0);
    pix(0, 8, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 12'hF00);
    pix(0, 5, 0);
    idle(4);
    // Out of range and test pattern
    pix(420, 100, 0);
    pix(420, 100, 1);
    pix(10, 200, 1);
    pix(10, 639, 1);
    idle(4);
    for (int i = 0; i < 2500; i++) begin
      bit r, d, we;
      r  = ($urandom_range(0, 299) == 0);
      d  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 19) == 0);
      step(r, d, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 479), $urandom_range(0, 639), $urandom_range(0, 3) == 0,
           we, $urandom_range(0, 15), $urandom_range(0, 4095));
    end
    idle(8);
    @(negedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count got=%0d need>=12", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
